// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared clock constants, divisor presets and tick mode type
package pong_pkg;

  localparam int unsigned CLK_HZ    = 100_000_000;
  localparam int unsigned DIV_1HZ   = CLK_HZ;
  localparam int unsigned DIV_2HZ   = CLK_HZ / 2;
  localparam int unsigned DIV_5HZ   = CLK_HZ / 5;
  localparam int unsigned DIV_500HZ = CLK_HZ / 500;
  localparam int unsigned DIV_25MHZ = CLK_HZ / 25_000_000;

  typedef enum logic {
    MODE_PERIODIC = 1'b0,
    MODE_ONESHOT  = 1'b1
  } tick_mode_e;

  // Channel-select width, never narrower than one bit.
  function automatic int ch_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_gen_if.sv
// rtl/tick_gen_if.sv - channel configuration write bus
interface tick_gen_if
  import pong_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 27
);
  localparam int CH_W = ch_width(NUM_CH);

  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_mode;

  modport master (output cfg_we, cfg_ch, cfg_div, cfg_mode);
  modport slave  (input  cfg_we, cfg_ch, cfg_div, cfg_mode);

endinterface

// File: rtl/tick_chan.sv
// rtl/tick_chan.sv - one divider channel with shadowed divisor/mode and one-shot support
module tick_chan
  import pong_pkg::*;
#(
  parameter int          CNT_W   = 27,
  parameter int unsigned DEF_DIV = DIV_1HZ
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ch_en,
  input  logic             sync_clr,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  input  logic             wr_mode,
  output logic             tick,
  output logic             lvl,
  output logic             pend,
  output logic             done
);
  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEF_DIV);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] sh_div;
  tick_mode_e       mode;
  tick_mode_e       sh_mode;
  logic             halted;
  logic             term;
  logic             apply;

  always_comb begin
    halted = !ch_en || (div == '0);
    term   = !halted && !done && (cnt == div - CNT_W'(1));
    apply  = pend && (sync_clr || term || halted);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      div     <= DEF;
      sh_div  <= DEF;
      mode    <= MODE_PERIODIC;
      sh_mode <= MODE_PERIODIC;
      tick    <= 1'b0;
      lvl     <= 1'b0;
      pend    <= 1'b0;
      done    <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (sync_clr) begin
        cnt <= '0;
        lvl <= 1'b0;
      end else if (term) begin
        cnt  <= '0;
        tick <= 1'b1;
        lvl  <= ~lvl;
        if (mode == MODE_ONESHOT) done <= 1'b1;
      end else if (!halted && !done) begin
        cnt <= cnt + CNT_W'(1);
      end
      // A new period always starts from zero so cnt stays below the new divisor.
      if (apply) begin
        div  <= sh_div;
        mode <= sh_mode;
        cnt  <= '0;
        pend <= 1'b0;
      end
      if (wr) begin
        sh_div  <= wr_div;
        sh_mode <= tick_mode_e'(wr_mode);
        pend    <= 1'b1;
        done    <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - multi-channel tick generator: config decode and channel fan-out
module tick_gen
  import pong_pkg::*;
#(
  parameter int          NUM_CH  = 4,
  parameter int          CNT_W   = 27,
  parameter int unsigned DEF_DIV = DIV_1HZ
) (
  input  logic              clk,
  input  logic              rst,
  tick_gen_if.slave         cfg,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_clr,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] lvl,
  output logic [NUM_CH-1:0] pend,
  output logic [NUM_CH-1:0] done
);
  localparam int CH_W = ch_width(NUM_CH);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr;
    // Exact-match decode: channel numbers >= NUM_CH select nothing.
    assign wr = cfg.cfg_we && (cfg.cfg_ch == CH_W'(i));

    tick_chan #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .ch_en    (ch_en[i]),
      .sync_clr (sync_clr),
      .wr       (wr),
      .wr_div   (cfg.cfg_div),
      .wr_mode  (cfg.cfg_mode),
      .tick     (tick[i]),
      .lvl      (lvl[i]),
      .pend     (pend[i]),
      .done     (done[i])
    );
  end

endmodule

// File: tb/tb_tick_gen.sv
// tb/tb_tick_gen.sv - directed self-checking bench for tick_gen
module tb_tick_gen;
  import pong_pkg::*;

  localparam int CNT_W   = 27;
  localparam int DEF_DIV = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] ch_en;
  logic       sync_clr;
  logic [3:0] tick, lvl, pend, done;
  logic [4:0] ch_en2;
  logic       sync_clr2;
  logic [4:0] tick2, lvl2, pend2, done2;

  int n_checks = 0;
  int n_pass   = 0;

  tick_gen_if #(.NUM_CH(4), .CNT_W(CNT_W)) bus ();
  tick_gen_if #(.NUM_CH(5), .CNT_W(CNT_W)) bus2 ();

  tick_gen #(.NUM_CH(4), .CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) dut (
    .clk(clk), .rst(rst), .cfg(bus), .ch_en(ch_en), .sync_clr(sync_clr),
    .tick(tick), .lvl(lvl), .pend(pend), .done(done)
  );

  tick_gen #(.NUM_CH(5), .CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) dut5 (
    .clk(clk), .rst(rst), .cfg(bus2), .ch_en(ch_en2), .sync_clr(sync_clr2),
    .tick(tick2), .lvl(lvl2), .pend(pend2), .done(done2)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ch_en = '0; ch_en2 = '0; sync_clr = 1'b0; sync_clr2 = 1'b0;
    bus.cfg_we = 1'b0; bus2.cfg_we = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic cfg_write(input int ch, input int div, input logic mode);
    bus.cfg_we   = 1'b1;
    bus.cfg_ch   = 2'(ch);
    bus.cfg_div  = CNT_W'(div);
    bus.cfg_mode = mode;
    step();
    bus.cfg_we   = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] tm;
    logic [3:0]  at12;
    ch_en = '0; ch_en2 = '0; sync_clr = 1'b0; sync_clr2 = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_div = '0; bus.cfg_mode = 1'b0;
    bus2.cfg_we = 1'b0; bus2.cfg_ch = '0; bus2.cfg_div = '0; bus2.cfg_mode = 1'b0;
    step(); step();
    n_checks++; if (tick !== 4'h0) $display("FAIL reset_tick: got %h expected 0", tick); else n_pass++;
    n_checks++; if (lvl  !== 4'h0) $display("FAIL reset_lvl: got %h expected 0", lvl);   else n_pass++;
    n_checks++; if (pend !== 4'h0) $display("FAIL reset_pend: got %h expected 0", pend); else n_pass++;
    n_checks++; if (done !== 4'h0) $display("FAIL reset_done: got %h expected 0", done); else n_pass++;
    rst = 1'b0;
    ch_en = 4'hF;
    at12 = '0;
    for (int c = 1; c <= 12; c++) begin
      step();
      tm[c-1] = tick[0];
      if (c == 12) at12 = tick;
    end
    n_checks++; if (tm !== 12'h800) $display("FAIL reset_default_div: got %h expected 800", tm); else n_pass++;
    n_checks++; if (at12 !== 4'hF) $display("FAIL reset_all_tick: got %h expected f", at12); else n_pass++;
  endtask

  task automatic test_periodic();
    logic [15:0] tm, lm;
    logic [3:0]  others;
    do_reset();
    cfg_write(0, DIV_25MHZ, 1'b0);
    n_checks++; if (pend !== 4'b0001) $display("FAIL periodic_pend_set: got %h expected 1", pend); else n_pass++;
    step();
    n_checks++; if (pend !== 4'b0000) $display("FAIL periodic_pend_clr: got %h expected 0", pend); else n_pass++;
    ch_en = 4'b0001;
    others = '0;
    for (int c = 1; c <= 16; c++) begin
      step();
      tm[c-1] = tick[0];
      lm[c-1] = lvl[0];
      others  = others | tick;
    end
    n_checks++; if (tm !== 16'h8888) $display("FAIL periodic_tick: got %h expected 8888", tm); else n_pass++;
    n_checks++; if (lm !== 16'h7878) $display("FAIL periodic_lvl: got %h expected 7878", lm); else n_pass++;
    n_checks++; if (others !== 4'b0001) $display("FAIL periodic_other_ch: got %h expected 1", others); else n_pass++;
  endtask

  task automatic test_div1();
    logic [5:0] tm, lm;
    do_reset();
    cfg_write(1, 1, 1'b0);
    step();
    ch_en = 4'b0010;
    for (int c = 1; c <= 6; c++) begin
      step();
      tm[c-1] = tick[1];
      lm[c-1] = lvl[1];
    end
    n_checks++; if (tm !== 6'h3F) $display("FAIL div1_tick: got %h expected 3f", tm); else n_pass++;
    n_checks++; if (lm !== 6'h15) $display("FAIL div1_lvl: got %h expected 15", lm); else n_pass++;
  endtask

  task automatic test_shadow();
    logic [19:0] tm, pm;
    do_reset();
    cfg_write(1, 10, 1'b0);
    step();
    ch_en = 4'b0010;
    for (int c = 1; c <= 20; c++) begin
      step();
      tm[c-1] = tick[1];
      pm[c-1] = pend[1];
      if (c == 5) begin
        bus.cfg_we = 1'b1; bus.cfg_ch = 2'd1; bus.cfg_div = CNT_W'(7); bus.cfg_mode = 1'b0;
      end
      if (c == 6) bus.cfg_div = CNT_W'(3);
      if (c == 7) bus.cfg_we = 1'b0;
    end
    n_checks++; if (tm !== 20'h49200) $display("FAIL shadow_tick: got %h expected 49200", tm); else n_pass++;
    n_checks++; if (pm !== 20'h001E0) $display("FAIL shadow_pend: got %h expected 001e0", pm); else n_pass++;
  endtask

  task automatic test_oneshot();
    int   n_ticks, first;
    logic done_early;
    do_reset();
    cfg_write(2, 5, 1'b1);
    step();
    ch_en = 4'b0100;
    n_ticks = 0; first = 0; done_early = 1'b1;
    for (int c = 1; c <= 55; c++) begin
      step();
      if (tick[2]) begin
        n_ticks++;
        if (first == 0) first = c;
      end
      if (c == 4) done_early = done[2];
    end
    n_checks++; if (n_ticks != 1) $display("FAIL oneshot_count: got %0d expected 1", n_ticks); else n_pass++;
    n_checks++; if (first != 5) $display("FAIL oneshot_first: got %0d expected 5", first); else n_pass++;
    n_checks++; if (done_early !== 1'b0) $display("FAIL oneshot_done_early: got %b expected 0", done_early); else n_pass++;
    n_checks++; if (done !== 4'b0100) $display("FAIL oneshot_done: got %h expected 4", done); else n_pass++;
    cfg_write(2, 5, 1'b1);
    n_checks++; if (done[2] !== 1'b0) $display("FAIL oneshot_rearm: got %b expected 0", done[2]); else n_pass++;
    n_checks++; if (pend[2] !== 1'b1) $display("FAIL oneshot_rearm_pend: got %b expected 1", pend[2]); else n_pass++;
  endtask

  task automatic test_sync_clr();
    logic [5:0] t0, t3;
    do_reset();
    cfg_write(0, 4, 1'b0);
    cfg_write(3, 6, 1'b0);
    step();
    ch_en = 4'b1001;
    for (int c = 1; c <= 7; c++) step();
    n_checks++; if (lvl !== 4'b1001) $display("FAIL sync_pre_lvl: got %h expected 9", lvl); else n_pass++;
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    n_checks++; if (tick !== 4'h0) $display("FAIL sync_tick_suppressed: got %h expected 0", tick); else n_pass++;
    n_checks++; if (lvl !== 4'h0) $display("FAIL sync_lvl: got %h expected 0", lvl); else n_pass++;
    for (int d = 1; d <= 6; d++) begin
      step();
      t0[d-1] = tick[0];
      t3[d-1] = tick[3];
    end
    n_checks++; if (t0 !== 6'h08) $display("FAIL sync_ch0_first: got %h expected 08", t0); else n_pass++;
    n_checks++; if (t3 !== 6'h20) $display("FAIL sync_ch3_first: got %h expected 20", t3); else n_pass++;
  endtask

  task automatic test_rst_mid();
    logic [11:0] tm;
    logic [19:0] zm;
    do_reset();
    cfg_write(0, 4, 1'b0);
    step();
    ch_en = 4'b0001;
    for (int c = 1; c <= 5; c++) step();
    cfg_write(0, 3, 1'b0);
    n_checks++; if ({pend[0], lvl[0]} !== 2'b11) $display("FAIL rstmid_pre: got %b expected 11", {pend[0], lvl[0]}); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({tick, lvl, pend, done} !== 16'h0) $display("FAIL rstmid_outputs: got %h expected 0", {tick, lvl, pend, done});
    else n_pass++;
    step();
    rst = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      step();
      tm[c-1] = tick[0];
    end
    n_checks++; if (tm !== 12'h800) $display("FAIL rstmid_default_div: got %h expected 800", tm); else n_pass++;
    ch_en = 4'b0000;
    cfg_write(0, 0, 1'b0);
    step();
    ch_en = 4'b0001;
    for (int c = 1; c <= 20; c++) begin
      step();
      zm[c-1] = tick[0];
    end
    n_checks++; if (zm !== 20'h0) $display("FAIL rstmid_div0: got %h expected 0", zm); else n_pass++;
  endtask

  task automatic test_out_of_range();
    logic [3:0] low_ticks;
    int         n4;
    do_reset();
    bus2.cfg_we = 1'b1; bus2.cfg_ch = 3'd5; bus2.cfg_div = CNT_W'(2); bus2.cfg_mode = 1'b0;
    step();
    bus2.cfg_ch = 3'd7;
    step();
    bus2.cfg_we = 1'b0;
    step();
    n_checks++; if (pend2 !== 5'h00) $display("FAIL oob_pend: got %h expected 00", pend2); else n_pass++;
    bus2.cfg_we = 1'b1; bus2.cfg_ch = 3'd4;
    step();
    bus2.cfg_we = 1'b0;
    n_checks++; if (pend2 !== 5'h10) $display("FAIL oob_valid_pend: got %h expected 10", pend2); else n_pass++;
    step();
    ch_en2 = 5'h1F;
    low_ticks = '0; n4 = 0;
    for (int c = 1; c <= 11; c++) begin
      step();
      low_ticks = low_ticks | tick2[3:0];
      if (tick2[4]) n4++;
    end
    n_checks++; if (low_ticks !== 4'h0) $display("FAIL oob_no_tick: got %h expected 0", low_ticks); else n_pass++;
    n_checks++; if (n4 != 5) $display("FAIL oob_ch4_ticks: got %0d expected 5", n4); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_div1();
    test_shadow();
    test_oneshot();
    test_sync_clr();
    test_rst_mid();
    test_out_of_range();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tick_gen.md
TICK_GEN -- requirements
Module: tick_gen

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent tick channels, range 1..16.
REQ-002 Parameter CNT_W, default 27: counter and divisor width in bits.
REQ-003 Parameter DEF_DIV, default 100_000_000: divisor loaded into every channel at reset.
REQ-004 clk  in  1  system clock, 100 MHz.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 cfg_we  in  1  one-cycle write strobe for divisor/mode of channel cfg_ch.
REQ-007 cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel of a config write.
REQ-008 cfg_div  in  CNT_W  new divisor (period in clk cycles).
REQ-009 cfg_mode  in  1  0 = periodic, 1 = one-shot.
REQ-010 ch_en  in  NUM_CH  per-channel run enable, level.
REQ-011 sync_clr  in  1  one-cycle strobe; restarts all channels in phase.
REQ-012 tick  out  NUM_CH  registered one-cycle pulse at end of each period.
REQ-013 lvl  out  NUM_CH  registered square wave; toggles on every tick.
REQ-014 pend  out  NUM_CH  high while a written divisor waits to be applied.
REQ-015 done  out  NUM_CH  one-shot finished flag, sticky until rearmed.

Function
REQ-016 Each channel: counter cnt runs 0..div-1 while ch_en high; tick asserts in the cycle after cnt == div-1; period is exactly div cycles.
REQ-017 div == 1: tick high every cycle; lvl toggles every cycle.
REQ-018 div == 0: channel halted; cnt held at 0; no tick; lvl held.
REQ-019 ch_en low: cnt, lvl and done frozen; tick low; rising ch_en resumes from held cnt.
REQ-020 Config write is shadowed: cfg_div/cfg_mode go to shadow registers and pend sets the next cycle.
REQ-021 Shadow transfers to active on the terminal count (cnt == div-1) or when the channel is halted (div == 0 or ch_en low); pend clears in the same cycle.
REQ-022 A second write while pend is high overwrites the shadow; last write wins; no tick lost or duplicated.
REQ-023 One-shot mode: after the first tick, cnt stops at 0, done sets, no further ticks; any config write to the channel clears done and rearms.
REQ-024 sync_clr: all cnt to 0, all lvl to 0, tick suppressed that cycle; pending shadows applied; takes priority over a coincident terminal count.
REQ-025 cfg_we with cfg_ch >= NUM_CH is ignored.
REQ-026 Counter arithmetic is unsigned CNT_W bits; cnt never exceeds div-1, so no wrap-around.
REQ-027 All outputs are registered; no combinational path from any input to any output.

Reset
REQ-028 rst asserted: cnt = 0, active and shadow div = DEF_DIV, mode = periodic, tick = 0, lvl = 0, pend = 0, done = 0.
REQ-029 rst mid-period discards all pending configuration; counting restarts from 0 on the first clk edge after deassertion when ch_en is high.

Structure
REQ-030 Shared package pong_pkg holds CLK_HZ = 100_000_000 and named divisor constants: DIV_1HZ, DIV_2HZ, DIV_5HZ, DIV_500HZ, DIV_25MHZ.
REQ-031 Each channel is one sub-module, tick_chan, generated NUM_CH times; tick_gen only decodes cfg_ch and fans out sync_clr.

Verification
REQ-032 NUM_CH=4, ch0 div=4, ch_en=1 -> tick every 4th cycle; lvl period 8 cycles.
REQ-033 ch1 div=10 running; write div=3 at cnt=5 -> pend=1 until cnt=9; ticks at the old spacing of 10, then every 3 cycles.
REQ-034 ch2 one-shot, div=5 -> a single tick 5 cycles after start; done=1; no further ticks over 50 cycles; a config write clears done.
REQ-035 ch0 div=4, ch3 div=6 running; sync_clr -> both restart; first ticks 4 and 6 cycles later; lvl=0 after the clear.
REQ-036 rst pulse mid-count with pend=1 -> all outputs 0, div=DEF_DIV, pend=0; div=0 and cfg_ch=5 writes produce no tick.
